// File: rtl/exp_pkg.sv
// Shared binary32 constants, flag indices and types for the exponential unit.
// Used by exp_final_stage and exp_fp_mul_rne.
package exp_pkg;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_BIAS   = 127;

  typedef logic [FP_SIGN_W+FP_EXP_W+FP_MAN_W-1:0] fp32_t;

  localparam fp32_t FP_PINF = 32'h7F80_0000;
  localparam fp32_t FP_QNAN = 32'h7FC0_0000;

  localparam int FLAG_SAT = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_NAN = 2;
  localparam int FLAG_W   = 3;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/exp_fp_mul_rne.sv
// Combinational binary32 multiply: round-to-nearest-even, flush-to-zero,
// with NaN/inf/overflow special cases.
module exp_fp_mul_rne
  import exp_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t res_o,
  output logic  nan_o,
  output logic  ovf_o
);

  logic               sa, sb, sr;
  logic [7:0]         ea, eb;
  logic [22:0]        ma, mb;
  logic               a_zero, b_zero;
  logic               a_inf, b_inf;
  logic               a_nan, b_nan;
  logic [47:0]        prod;
  logic [22:0]        man;
  logic               grd, stk, inc;
  logic [23:0]        rnd;
  logic signed [10:0] exp_s;

  assign sa = a_i[31];
  assign sb = b_i[31];
  assign ea = a_i[30:23];
  assign eb = b_i[30:23];
  assign ma = a_i[22:0];
  assign mb = b_i[22:0];
  assign sr = sa ^ sb;

  // Denormal operands count as zero.
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (ma == '0);
  assign b_inf  = (eb == 8'hFF) && (mb == '0);
  assign a_nan  = (ea == 8'hFF) && (ma != '0);
  assign b_nan  = (eb == 8'hFF) && (mb != '0);

  always_comb begin
    res_o = '0;
    nan_o = 1'b0;
    ovf_o = 1'b0;
    prod  = {1'b1, ma} * {1'b1, mb};
    if (prod[47]) begin
      man = prod[46:24];
      grd = prod[23];
      stk = |prod[22:0];
    end else begin
      man = prod[45:23];
      grd = prod[22];
      stk = |prod[21:0];
    end
    inc   = grd & (stk | man[0]);
    rnd   = {1'b0, man} + {23'd0, inc};
    exp_s = $signed({3'b0, ea}) + $signed({3'b0, eb})
          - 11'sd127
          + $signed({10'b0, prod[47]})
          + $signed({10'b0, rnd[23]});
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      res_o = FP_QNAN;
      nan_o = 1'b1;
    end else if (a_inf | b_inf) begin
      res_o = {sr, FP_PINF[30:0]};
    end else if (a_zero | b_zero) begin
      res_o = {sr, 31'd0};
    end else if (exp_s >= 11'sd255) begin
      res_o = {sr, FP_PINF[30:0]};
      ovf_o = 1'b1;
    end else if (exp_s <= 11'sd0) begin
      res_o = {sr, 31'd0};
    end else begin
      res_o = {sr, exp_s[7:0], rnd[FP_MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/exp_final_stage.sv
// Final exp stage: fixed mul -> float32 convert -> float mul -> output reg.
// Define EXP_FINAL_DEBUG_EN to expose the S1 product on D_taylor_output.
module exp_final_stage
  import exp_pkg::*;
#(
  parameter int INT_W  = 3,
  parameter int FRAC_W = 23
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [INT_W+FRAC_W-1:0] FIXED_taylor_input,
  input  logic [INT_W+FRAC_W-1:0] FIXED_e_input,
  input  logic [31:0]             FLOAT_e_input,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [31:0]             FLOAT_result_output,
  output logic [2:0]              FLAGS_output
`ifdef EXP_FINAL_DEBUG_EN
  ,
  output logic [INT_W+FRAC_W-1:0] D_taylor_output
`endif
);

  localparam int W = INT_W + FRAC_W;

  logic           s1_v_q, s2_v_q, s3_v_q, out_v_q;
  logic           s1_v_d, s2_v_d, s3_v_d, out_v_d;
  logic           s1_ld, s2_ld, s3_ld, out_ld;
  logic [W-1:0]   s1_prod_q;
  logic           s1_sat_q;
  fp32_t          s1_fe_q;
  fp32_t          s2_fp_q, s2_fe_q;
  logic           s2_sat_q;
  fp32_t          s3_res_q, out_res_q;
  flags_t         s3_flags_q, out_flags_q;

  logic [2*W-1:0] prod_full;
  logic [W-1:0]   prod_kept;
  logic           prod_sat;
  logic           unused_lo;
  logic [5:0]     lead;
  logic [W+22:0]  norm;
  logic           unused_norm;
  fp32_t          cvt;
  fp32_t          mul_res;
  logic           mul_nan, mul_ovf;
  flags_t         mul_flags;

  // Ready ripples back from OUT_READY in the same cycle.
  assign out_ld   = !out_v_q || OUT_READY;
  assign s3_ld    = !s3_v_q || out_ld;
  assign s2_ld    = !s2_v_q || s3_ld;
  assign s1_ld    = !s1_v_q || s2_ld;
  assign IN_READY = s1_ld;

  assign s1_v_d  = s1_ld  ? IN_VALID : s1_v_q;
  assign s2_v_d  = s2_ld  ? s1_v_q   : s2_v_q;
  assign s3_v_d  = s3_ld  ? s2_v_q   : s3_v_q;
  assign out_v_d = out_ld ? s3_v_q   : out_v_q;

  assign prod_full = FIXED_taylor_input * FIXED_e_input;
  assign prod_sat  = |prod_full[2*W-1:FRAC_W+W];
  assign prod_kept = prod_sat ? '1 : prod_full[FRAC_W +: W];
  assign unused_lo = ^prod_full[FRAC_W-1:0];

  // Normalise so the leading one lands at the top bit of norm.
  always_comb begin
    lead = '0;
    for (int i = 0; i < W; i++) begin
      if (s1_prod_q[i]) lead = 6'(i);
    end
    norm = {s1_prod_q, {FP_MAN_W{1'b0}}} << (6'(W - 1) - lead);
    if (s1_prod_q == '0) begin
      cvt = '0;
    end else begin
      cvt = {1'b0, 8'(int'(lead) + FP_BIAS - FRAC_W),
             norm[W+21 -: FP_MAN_W]};
    end
  end

  assign unused_norm = ^{norm[W+22], norm[W-2:0]};

  exp_fp_mul_rne u_mul (
    .a_i   (s2_fp_q),
    .b_i   (s2_fe_q),
    .res_o (mul_res),
    .nan_o (mul_nan),
    .ovf_o (mul_ovf)
  );

  always_comb begin
    mul_flags           = '0;
    mul_flags[FLAG_NAN] = mul_nan;
    mul_flags[FLAG_OVF] = mul_ovf;
    mul_flags[FLAG_SAT] = s2_sat_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s3_v_q      <= 1'b0;
      out_v_q     <= 1'b0;
      s1_prod_q   <= '0;
      s1_sat_q    <= 1'b0;
      s1_fe_q     <= '0;
      s2_fp_q     <= '0;
      s2_fe_q     <= '0;
      s2_sat_q    <= 1'b0;
      s3_res_q    <= '0;
      s3_flags_q  <= '0;
      out_res_q   <= '0;
      out_flags_q <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      s3_v_q  <= s3_v_d;
      out_v_q <= out_v_d;
      if (s1_ld) begin
        s1_prod_q <= prod_kept;
        s1_sat_q  <= prod_sat;
        s1_fe_q   <= FLOAT_e_input;
      end
      if (s2_ld) begin
        s2_fp_q  <= cvt;
        s2_fe_q  <= s1_fe_q;
        s2_sat_q <= s1_sat_q;
      end
      if (s3_ld) begin
        s3_res_q   <= mul_res;
        s3_flags_q <= mul_flags;
      end
      if (out_ld) begin
        out_res_q   <= s3_res_q;
        out_flags_q <= s3_flags_q;
      end
    end
  end

  assign OUT_VALID           = out_v_q;
  assign FLOAT_result_output = out_res_q;
  assign FLAGS_output        = out_flags_q;

`ifdef EXP_FINAL_DEBUG_EN
  assign D_taylor_output = s1_prod_q;
`endif

endmodule

// File: tb/tb_exp_final_stage.sv
// Self-checking bench for exp_final_stage (INT_W=3, FRAC_W=23).
// Scoreboard model plus directed vectors, latency, backpressure and reset.
module tb_exp_final_stage;

  localparam int INT_W  = 3;
  localparam int FRAC_W = 23;
  localparam int W      = INT_W + FRAC_W;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] taylor = '0;
  logic [W-1:0] efix = '0;
  logic [31:0]  fe = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b1;
  logic [31:0]  res;
  logic [2:0]   flags;
`ifdef EXP_FINAL_DEBUG_EN
  logic [W-1:0] dbg;
`endif

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [34:0] exp_q[$];

  always #5 CLK = ~CLK;

  exp_final_stage #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .IN_VALID            (IN_VALID),
    .IN_READY            (IN_READY),
    .FIXED_taylor_input  (taylor),
    .FIXED_e_input       (efix),
    .FLOAT_e_input       (fe),
    .OUT_VALID           (OUT_VALID),
    .OUT_READY           (OUT_READY),
    .FLOAT_result_output (res),
    .FLAGS_output        (flags)
`ifdef EXP_FINAL_DEBUG_EN
    ,
    .D_taylor_output     (dbg)
`endif
  );

  function automatic logic [31:0] to_float(input longint unsigned v);
    int p;
    longint unsigned m;
    if (v == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    m = ((v << 23) >> p) & 64'h7FFFFF;
    return {1'b0, 8'(p - FRAC_W + 127), m[22:0]};
  endfunction

  // Returns {nan, ovf, result}
  function automatic logic [33:0] fmul(input logic [31:0] a, b);
    int ea, eb, m, k, e;
    logic s, an, bn, ai, bi, az, bz;
    longint unsigned p, q, r, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {2'b10, 32'h7FC00000};
    if (ai || bi) return {2'b00, s, 31'h7F800000};
    if (az || bz) return {2'b00, s, 31'h0};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    m = 0;
    for (int i = 0; i < 64; i++) if (p[i]) m = i;
    k = m - 23;
    q = p >> k;
    r = p - (q << k);
    half = 64'd1 << (k - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      m = m + 1;
    end
    e = ea + eb - 127 + (m - 46);
    if (e >= 255) return {2'b01, s, 31'h7F800000};
    if (e <= 0) return {2'b00, s, 31'h0};
    return {2'b00, s, 8'(e), q[22:0]};
  endfunction

  // Returns {flags[2:0], result}
  function automatic logic [34:0] model(input logic [W-1:0] t, e,
                                        input logic [31:0] f);
    longint unsigned kept;
    logic sat;
    logic [33:0] r;
    kept = (64'(t) * 64'(e)) >> FRAC_W;
    sat = kept >= (64'd1 << W);
    if (sat) kept = (64'd1 << W) - 1;
    r = fmul(to_float(kept), f);
    return {r[33], r[32], sat, r[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;

  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got res %h flags %b, none expected",
                 res, flags);
      end else if ({flags, res} !== exp_q[0]) begin
        errors++;
        $display("FAIL out_data: got %h expected %h", {flags, res}, exp_q[0]);
      end
    end
    if (prev_stall) begin
      checks++;
      if (OUT_VALID !== 1'b1 || {flags, res} !== prev_out) begin
        errors++;
        $display("FAIL stall_hold: got v=%b %h expected v=1 %h",
                 OUT_VALID, {flags, res}, prev_out);
      end
    end
    prev_stall = RST_N && (OUT_VALID === 1'b1) && !OUT_READY;
    prev_out   = {flags, res};
    if (!RST_N) begin
      exp_q.delete();
    end else begin
      if (OUT_VALID === 1'b1 && OUT_READY) begin
        out_cnt++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (IN_VALID && IN_READY === 1'b1)
        exp_q.push_back(model(taylor, efix, fe));
    end
  end

  task automatic send(input logic [W-1:0] t, e, input logic [31:0] f,
                      output int tries);
    logic acc;
    IN_VALID = 1'b1;
    taylor = t;
    efix = e;
    fe = f;
    tries = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      acc = IN_READY;
      tries++;
      @(posedge CLK);
      #1;
      if (acc) break;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      n++;
      if (OUT_VALID) break;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) @(negedge CLK);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [W-1:0] vt[11];
  logic [W-1:0] ve[11];
  logic [31:0]  vf[11];
  logic [W-1:0] bt[6];
  logic [W-1:0] be[6];
  logic [31:0]  bf[6];

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n, tries, sent, c0;
    logic acc;

    vt = '{26'h0000000, 26'h3FFFFFF, 26'h1000000, 26'h0800000, 26'h1800000,
           26'h0000000, 26'h0800000, 26'h0800000, 26'h0800000, 26'h0000001,
           26'h0ABCDEF};
    ve = '{26'h0800000, 26'h3FFFFFF, 26'h1000000, 26'h0800000, 26'h0800000,
           26'h0800000, 26'h0800000, 26'h0800000, 26'h0800000, 26'h0800000,
           26'h0912345};
    vf = '{32'h40000000, 32'h3F800000, 32'h7F000000, 32'h7FC00001,
           32'h3F800001, 32'hFF800000, 32'h00400000, 32'hC0000000,
           32'h7F800000, 32'h00800000, 32'h3FB504F3};
    for (int i = 0; i < 6; i++) begin
      bt[i] = 26'h0800000 + 26'(i * 26'h0123457);
      be[i] = 26'h0800000 + 26'(i * 26'h0011111);
      bf[i] = 32'h3F800000 + 32'(i * 32'h00100000);
    end

    chk("m_identity", 64'(model(26'h0800000, 26'h0800000, 32'h40000000)),
        64'({3'b000, 32'h40000000}));
    chk("m_sat", 64'(model(26'h3FFFFFF, 26'h3FFFFFF, 32'h3F800000)),
        64'({3'b001, 32'h40FFFFFF}));
    chk("m_ovf", 64'(model(26'h1000000, 26'h1000000, 32'h7F000000)),
        64'({3'b010, 32'h7F800000}));
    chk("m_nan", 64'(model(26'h0800000, 26'h0800000, 32'h7FC00001)),
        64'({3'b100, 32'h7FC00000}));
    chk("m_tie", 64'(model(26'h1800000, 26'h0800000, 32'h3F800001)),
        64'({3'b000, 32'h40400002}));
    chk("m_inf0", 64'(model(26'h0000000, 26'h0800000, 32'hFF800000)),
        64'({3'b100, 32'h7FC00000}));

    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_result", 64'(res), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    @(posedge CLK);
    #1;

    send(26'h0800000, 26'h0800000, 32'h40000000, tries);
    wait_out(n);
    chk("lat_identity", 64'(n - 1), 64'd3);
    chk("res_identity", 64'(res), 64'h40000000);
    chk("flags_identity", 64'(flags), 64'd0);

    send(26'h0000000, 26'h0800000, 32'h40000000, tries);
    wait_out(n);
    chk("res_zero", 64'(res), 64'h00000000);
    chk("flags_zero", 64'(flags), 64'd0);

    send(26'h3FFFFFF, 26'h3FFFFFF, 32'h3F800000, tries);
`ifdef EXP_FINAL_DEBUG_EN
    @(negedge CLK);
    chk("dbg_sat", 64'(dbg), 64'h3FFFFFF);
`endif
    wait_out(n);
    chk("res_sat", 64'(res), 64'h40FFFFFF);
    chk("flags_sat", 64'(flags), 64'b001);

    send(26'h1000000, 26'h1000000, 32'h7F000000, tries);
    wait_out(n);
    chk("res_ovf", 64'(res), 64'h7F800000);
    chk("flags_ovf", 64'(flags), 64'b010);

    send(26'h0800000, 26'h0800000, 32'h7FC00001, tries);
    wait_out(n);
    chk("res_nan", 64'(res), 64'h7FC00000);
    chk("flags_nan", 64'(flags), 64'b100);
    drain();

    @(posedge CLK);
    #1;
    for (int i = 0; i < 11; i++) begin
      send(vt[i], ve[i], vf[i], tries);
      chk("thru_tries", 64'(tries), 64'd1);
    end
    drain();

    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    c0 = out_cnt;
    sent = 0;
    IN_VALID = 1'b1;
    taylor = bt[0];
    efix = be[0];
    fe = bf[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      if (acc) begin
        sent++;
        if (sent < 6) begin
          taylor = bt[sent];
          efix = be[sent];
          fe = bf[sent];
        end else begin
          IN_VALID = 1'b0;
        end
      end
    end
    chk("bp_accepted", 64'(sent), 64'd4);
    chk("bp_in_ready", 64'(IN_READY), 64'd0);
    chk("bp_out_valid", 64'(OUT_VALID), 64'd1);
    OUT_READY = 1'b1;
    for (int c = 0; c < 40 && sent < 6; c++) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      if (acc) begin
        sent++;
        if (sent < 6) begin
          taylor = bt[sent];
          efix = be[sent];
          fe = bf[sent];
        end
      end
    end
    IN_VALID = 1'b0;
    chk("bp_sent", 64'(sent), 64'd6);
    drain();
    chk("bp_out_cnt", 64'(out_cnt - c0), 64'd6);

    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) send(bt[i], be[i], bf[i], tries);
    RST_N = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("mid_rst_result", 64'(res), 64'd0);
    chk("mid_rst_flags", 64'(flags), 64'd0);
    chk("mid_rst_in_ready", 64'(IN_READY), 64'd1);
    c0 = out_cnt;
    repeat (8) @(negedge CLK);
    chk("mid_rst_no_stale", 64'(out_cnt - c0), 64'd0);

    @(posedge CLK);
    #1;
    send(26'h1800000, 26'h0800000, 32'h3F800001, tries);
    wait_out(n);
    chk("post_rst_tie", 64'(res), 64'h40400002);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
